// File: rtl/ex_mul_if.sv
// Handshake/data bundle between the Execute stage and the iterative multiplier.
// state_dbg mirrors the sequencer FSM state (0=IDLE, 1=BUSY, 2=DONE).
interface ex_mul_if #(
    parameter int WIDTH = 64
);
    // start is held by the stall until valid_out; flush overrides start.
    // valid_out pulses for one cycle and carries result/rd_out.
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       rd_in;
    logic             stall;
    logic             busy;
    logic             valid_out;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic [1:0]       state_dbg;

    modport master (
        output start, flush, op_a, op_b, rd_in,
        input  stall, busy, valid_out, result, rd_out, state_dbg
    );

    modport slave (
        input  start, flush, op_a, op_b, rd_in,
        output stall, busy, valid_out, result, rd_out, state_dbg
    );
endinterface

// File: rtl/ex_mul_sequencer.sv
// Iterative shift-add multiplier sequenced beside the EX ALU; stalls IF/ID/EX while busy.
// Optional EX_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module ex_mul_sequencer #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic   clk,
    input  logic   resetl,
    ex_mul_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       rd_out_q;
    logic             valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic             last_iter;
    logic             finish;
    logic             accept;

    // Partial product of mcand and the low BITS_PER_CYCLE multiplier bits, mod 2^WIDTH.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    always_comb begin
        acc_next    = acc + partial;
        mplier_next = mplier >> BITS_PER_CYCLE;
        last_iter   = (count == CW'(N - 1));
`ifdef EX_MUL_EARLY_TERM_EN
        finish      = last_iter || (mplier_next == '0);
`else
        finish      = last_iter;
`endif
        accept      = bus.start && !bus.flush;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: load on accept, iterate in BUSY, publish on the edge into DONE.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= (state_next == BUSY);
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        rd_q   <= bus.rd_in;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                BUSY: begin
                    if (!bus.flush) begin
                        acc    <= acc_next;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier_next;
                        count  <= count + 1'b1;
                        if (finish) begin
                            result_q <= acc_next;
                            rd_out_q <= rd_q;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stall is forced low during reset so the pipeline is not held by a stale start.
    assign bus.stall     = resetl && (((state == IDLE) && accept) || (state == BUSY));
    assign bus.busy      = busy_q;
    assign bus.valid_out = valid_q;
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_out_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Bench for ex_mul_sequencer: BPC=1 and BPC=4 instances run side by side against an arithmetic model.
// Honours EX_MUL_EARLY_TERM_EN when computing expected latency.
module tb_ex_mul_sequencer;
    localparam int W = 64;

    logic clk = 1'b0;
    logic resetl = 1'b0;
    always #5 clk = ~clk;

    logic          start0, start4, flush;
    logic [W-1:0]  op_a, op_b;
    logic [4:0]    rd_in;

    ex_mul_if #(.WIDTH(W)) if0 ();
    ex_mul_if #(.WIDTH(W)) if4 ();

    assign if0.start = start0;
    assign if0.flush = flush;
    assign if0.op_a  = op_a;
    assign if0.op_b  = op_b;
    assign if0.rd_in = rd_in;
    assign if4.start = start4;
    assign if4.flush = flush;
    assign if4.op_a  = op_a;
    assign if4.op_b  = op_b;
    assign if4.rd_in = rd_in;

    ex_mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .resetl(resetl), .bus(if0));
    ex_mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .resetl(resetl), .bus(if4));

    logic          v   [2];
    logic          st  [2];
    logic          bz  [2];
    logic [W-1:0]  res [2];
    logic [4:0]    rdo [2];
    logic [1:0]    sdb [2];
    assign v[0] = if0.valid_out;  assign v[1] = if4.valid_out;
    assign st[0] = if0.stall;     assign st[1] = if4.stall;
    assign bz[0] = if0.busy;      assign bz[1] = if4.busy;
    assign res[0] = if0.result;   assign res[1] = if4.result;
    assign rdo[0] = if0.rd_out;   assign rdo[1] = if4.rd_out;
    assign sdb[0] = if0.state_dbg; assign sdb[1] = if4.state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_res [2];
    logic [4:0]   last_rd  [2];
    int           bpc_of   [2] = '{1, 4};

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected number of BUSY cycles for multiplier b.
    function automatic int exp_lat(input logic [W-1:0] b, input int bpc);
        int nbits;
        int n;
        nbits = 0;
        for (int i = 0; i < W; i++) if (b[i]) nbits = i + 1;
        n = W / bpc;
`ifdef EX_MUL_EARLY_TERM_EN
        n = (nbits == 0) ? 1 : (nbits + bpc - 1) / bpc;
`endif
        return n;
    endfunction

    task automatic check_idle_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, 64'(bz[d]), 64'd0);
            chk({tag, "_valid"}, 64'(v[d]), 64'd0);
            chk({tag, "_stall"}, 64'(st[d]), 64'd0);
            chk({tag, "_result"}, res[d], 64'd0);
            chk({tag, "_rd_out"}, 64'(rdo[d]), 64'd0);
            chk({tag, "_state"}, 64'(sdb[d]), 64'd0);
        end
    endtask

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd, input int flush_at);
        int lat  [2];
        int scnt [2];
        int fin  [2];
        logic [W-1:0] expr;
        expr = a * b;
        for (int d = 0; d < 2; d++) begin
            lat[d]  = exp_lat(b, bpc_of[d]);
            scnt[d] = 1;
            fin[d]  = 0;
        end
        @(negedge clk);
        op_a = a; op_b = b; rd_in = rd; flush = 1'b0;
        start0 = 1'b1; start4 = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk("stall_on_start", 64'(st[d]), 64'd1);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (flush_at != 0 && cyc == flush_at) begin
                flush = 1'b1; start0 = 1'b0; start4 = 1'b0;
                @(negedge clk);
                flush = 1'b0;
                for (int d = 0; d < 2; d++) begin
                    chk("flush_busy", 64'(bz[d]), 64'd0);
                    chk("flush_stall", 64'(st[d]), 64'd0);
                    chk("flush_valid", 64'(v[d]), 64'd0);
                    chk("flush_result", res[d], last_res[d]);
                end
                @(negedge clk);
                for (int d = 0; d < 2; d++) chk("flush_no_late_valid", 64'(v[d]), 64'd0);
                return;
            end
            for (int d = 0; d < 2; d++) begin
                if (fin[d] == 0) begin
                    if (v[d]) begin
                        fin[d] = cyc;
                        chk("valid_cycle", 64'(cyc), 64'(lat[d] + 1));
                        chk("stall_cycles", 64'(scnt[d]), 64'(lat[d] + 1));
                        chk("done_stall", 64'(st[d]), 64'd0);
                        chk("done_busy", 64'(bz[d]), 64'd0);
                        chk("result", res[d], expr);
                        chk("rd_out", 64'(rdo[d]), 64'(rd));
                        last_res[d] = expr;
                        last_rd[d]  = rd;
                        if (d == 0) start0 = 1'b0; else start4 = 1'b0;
                    end else if (cyc > lat[d] + 1) begin
                        fin[d] = cyc;
                        chk("valid_timeout", 64'(cyc), 64'(lat[d] + 1));
                        if (d == 0) start0 = 1'b0; else start4 = 1'b0;
                    end else if (st[d]) begin
                        scnt[d]++;
                    end
                end else if (cyc == fin[d] + 1) begin
                    chk("valid_pulse", 64'(v[d]), 64'd0);
                    chk("hold_result", res[d], last_res[d]);
                    chk("hold_rd_out", 64'(rdo[d]), 64'(last_rd[d]));
                end
            end
            if (fin[0] != 0 && fin[1] != 0 && cyc > fin[0] && cyc > fin[1]) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        start0 = 1'b0; start4 = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0; rd_in = '0;
        for (int d = 0; d < 2; d++) begin last_res[d] = '0; last_rd[d] = '0; end

        resetl = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_zero("reset_held");
        @(negedge clk);
        resetl = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_released");

        do_mul(64'd3, 64'd5, 5'd7, 0);
        do_mul(64'h8000_0000_0000_0000, 64'd2, 5'd1, 0);
        do_mul({W{1'b1}}, {W{1'b1}}, 5'd31, 0);
        do_mul(64'd123, 64'd456, 5'd12, 0);
        do_mul(64'd9, 64'd5, 5'd4, 0);
        do_mul($urandom, 64'd0, 5'd2, 0);

        for (int k = 0; k < 5; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            do_mul(a, b, 5'($urandom_range(0, 31)), 0);
        end
        for (int k = 0; k < 4; k++) begin
            a = {$urandom, $urandom};
            b = 64'($urandom_range(1, 4095));
            do_mul(a, b, 5'($urandom_range(0, 31)), 0);
        end

        // Flush on the 10th BUSY cycle, then confirm a fresh MUL still completes.
        a = {$urandom, $urandom};
        b = {1'b1, 31'($urandom), 32'($urandom)};
        do_mul(a, b, 5'd9, 10);
        do_mul(64'd11, 64'd13, 5'd10, 0);

        // start together with flush in IDLE must be ignored.
        @(negedge clk);
        op_a = 64'd4; op_b = 64'd4; rd_in = 5'd3;
        start0 = 1'b1; start4 = 1'b1; flush = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk("start_flush_stall", 64'(st[d]), 64'd0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("start_flush_busy", 64'(bz[d]), 64'd0);
        start0 = 1'b0; start4 = 1'b0; flush = 1'b0;

        // Reset in the middle of a multiply.
        @(negedge clk);
        op_a = {$urandom, $urandom}; op_b = {1'b1, 63'd77}; rd_in = 5'd21;
        start0 = 1'b1; start4 = 1'b1;
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("pre_reset_busy", 64'(bz[d]), 64'd1);
        resetl = 1'b0;
        #1;
        check_idle_zero("midop_reset");
        start0 = 1'b0; start4 = 1'b0;
        @(negedge clk);
        resetl = 1'b1;
        for (int d = 0; d < 2; d++) begin last_res[d] = '0; last_rd[d] = '0; end
        do_mul(64'd6, 64'd7, 5'd3, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
